// File: rtl/fifo_rd_packer_pkg.sv
// Shared FIFO read-path definitions: packer FSM encoding and default lane geometry.
package fifo_rd_packer_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/circular_fifo_rev1.sv
// Circular FIFO of 2**ADDR_WIDTH entries; read data registered, valid the cycle after rd_cs&rd_en.
// Writes while full and reads while empty are ignored; no other backpressure.
module circular_fifo_rev1
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_cs && rd_en && !empty;
  assign data_out = data_out_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[ADDR_WIDTH-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
    end
    if (do_rd) begin
      data_out_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      rd_ptr_d   = rd_ptr_q + (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a FIFO byte-by-byte (2 cycles/byte) into LANES-wide little-endian words; flush emits partials.
// Output holds in S_OUT until m_valid&m_ready; no FIFO reads while a word is waiting.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  output logic                          fifo_rd_cs,
  output logic                          fifo_rd_en,
  input  logic                          flush,
  output logic [DATA_WIDTH*LANES-1:0]   m_data,
  output logic [$clog2(LANES):0]        m_bytes,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CNT_WIDTH-1:0]          word_cnt
);
  localparam int              IW       = $clog2(LANES) + 1;
  localparam logic [IW-1:0]   FULL_IDX = IW'(LANES);

  state_t                             state_q, state_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]   lanes_q, lanes_d;
  logic                               flush_pend_q, flush_pend_d;
  logic [CNT_WIDTH-1:0]               word_cnt_q, word_cnt_d;
  logic                               rd_q, rd_d;
  logic                               m_valid_q, m_valid_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lanes_d      = lanes_q;
    flush_pend_d = flush_pend_q;
    word_cnt_d   = word_cnt_q;

    // A flush only matters if there is, or is about to be, something to emit.
    if (flush && ((idx_q != '0) || (state_q == S_REQ) || (state_q == S_CAP)))
      flush_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty)
          state_d = S_REQ;
        else if (flush_pend_q && (idx_q != '0))
          state_d = S_OUT;
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        for (int i = 0; i < LANES; i++)
          if (idx_q == IW'(i)) lanes_d[i] = fifo_data_out;
        idx_d = idx_q + IW'(1);
        if (idx_d == FULL_IDX)
          state_d = S_OUT;
        else if (!fifo_empty)
          state_d = S_REQ;
        else
          state_d = S_IDLE;
      end
      S_OUT: begin
        if (m_ready) begin
          lanes_d      = '0;
          idx_d        = '0;
          flush_pend_d = 1'b0;
          word_cnt_d   = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_WIDTH'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered copies of the next state so they never see m_ready combinationally.
    rd_d      = (state_d == S_REQ);
    m_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      lanes_q      <= '0;
      flush_pend_q <= 1'b0;
      word_cnt_q   <= '0;
      rd_q         <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lanes_q      <= lanes_d;
      flush_pend_q <= flush_pend_d;
      word_cnt_q   <= word_cnt_d;
      rd_q         <= rd_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign fifo_rd_cs = rd_q;
  assign fifo_rd_en = rd_q;
  assign m_valid    = m_valid_q;
  assign m_data     = lanes_q;
  assign m_bytes    = idx_q;
  assign word_cnt   = word_cnt_q;
endmodule
